// File: rtl/keypad_controller.sv
// Keypad front end: scan-column divider, press/release debouncer and a
// first-word fall-through keystroke FIFO with a sticky overflow flag.
module keypad_controller #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int AW              = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       scan_en,
  input  logic [7:0] key_code,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       valid,
  output logic       full,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REL_DB
  } state_t;

  // ---------------------------------------------------------------- divider
  logic [DW-1:0] div_cnt;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                div_cnt <= '0;
    else if (div_cnt == DIV_MAX) div_cnt <= '0;
    else                       div_cnt <= div_cnt + DW'(1);
  end

  assign scan_en = (div_cnt == DIV_MAX);

  // -------------------------------------------------------------- debouncer
  state_t        state_q, state_d;
  logic [7:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (key_code != 8'd0) begin
          cand_d  = key_code;
          cnt_d   = '0;
          state_d = S_PRESS_DB;
        end
      end
      S_PRESS_DB: begin
        if (key_code != cand_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          push_req = 1'b1;
          state_d  = S_HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HELD: begin
        // A different nonzero code while held is rollover and is ignored.
        if (key_code == 8'd0) begin
          cnt_d   = '0;
          state_d = S_REL_DB;
        end
      end
      S_REL_DB: begin
        if (key_code != 8'd0) begin
          state_d = S_HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_pop, do_push, drop;

  assign valid   = (count != '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = rd_en && valid;
  // A same-cycle pop frees the slot, so a push into a full queue still lands.
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;
  assign rd_data = valid ? mem[rd_ptr] : 8'd0;

  // NOTE: the storage array has no reset; valid gates rd_data, so stale
  // contents are never visible and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= cand_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
      else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
    end
  end

  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_controller.sv
// Directed bench for keypad_controller with SCAN_DIV=8, DEBOUNCE_CYCLES=4,
// FIFO_DEPTH=4; inputs change and outputs are sampled on the falling edge.
module tb_keypad_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_en;
  logic [7:0] key_code;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       valid;
  logic       full;
  logic       overflow;
  logic       clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_controller #(
    .SCAN_DIV(8),
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH(4),
    .AW(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_en(scan_en),
    .key_code(key_code),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .valid(valid),
    .full(full),
    .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and return on the following falling edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Clean press: code stable 6 cycles (push on the 5th edge), then released
  // for 6 cycles so the debouncer returns to idle.
  task automatic press(input logic [7:0] code);
    key_code = code;
    cyc(6);
    key_code = 8'd0;
    cyc(6);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check(tag, {31'd0, valid}, 32'd1);
    check(tag, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    key_code = 8'd0;
    rd_en    = 1'b0;
    clr_ovf  = 1'b0;
    cyc(2);

    // Reset state
    check("rst scan_en",  {31'd0, scan_en},  32'd0);
    check("rst rd_data",  {24'd0, rd_data},  32'd0);
    check("rst valid",    {31'd0, valid},    32'd0);
    check("rst full",     {31'd0, full},     32'd0);
    check("rst overflow", {31'd0, overflow}, 32'd0);

    // 1. Divider: value before edge k is the pulse seen by edge k
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      check($sformatf("div edge %0d", k), {31'd0, scan_en}, {31'd0, (k % 8) == 0});
      cyc();
    end
    for (int k = 1; k <= 12; k++) cyc();
    rst_n = 1'b0;
    cyc();
    check("div in reset", {31'd0, scan_en}, 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("div re-release edge %0d", k), {31'd0, scan_en}, {31'd0, k == 8});
      cyc();
    end

    // 2. Clean press; also a pop strobe while empty must be ignored
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("empty pop valid", {31'd0, valid}, 32'd0);
    key_code = 8'd53;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check($sformatf("press latency %0d", i), {31'd0, valid}, {31'd0, i >= 5});
    end
    key_code = 8'd0;
    cyc(6);
    pop_expect("press head", 8'd53);
    check("press single valid",   {31'd0, valid},   32'd0);
    check("press single rd_data", {24'd0, rd_data}, 32'd0);

    // 3. Bounce then release glitch
    for (int i = 0; i < 12; i++) begin
      key_code = ((i / 2) % 2 == 0) ? 8'd53 : 8'd0;
      cyc();
    end
    key_code = 8'd0;
    cyc(6);
    check("bounce no push", {31'd0, valid}, 32'd0);
    key_code = 8'd50; cyc(6);
    key_code = 8'd0;  cyc(2);
    key_code = 8'd50; cyc(6);
    key_code = 8'd0;  cyc(6);
    pop_expect("glitch head", 8'd50);
    check("glitch single", {31'd0, valid}, 32'd0);

    // 4. Rollover ignored, then a fresh press of the second key
    key_code = 8'd49; cyc(6);
    key_code = 8'd52; cyc(6);
    key_code = 8'd0;  cyc(6);
    check("rollover one entry", {31'd0, full}, 32'd0);
    press(8'd52);
    pop_expect("rollover first", 8'd49);
    pop_expect("rollover second", 8'd52);
    check("rollover drained", {31'd0, valid}, 32'd0);

    // 5. Full and overflow
    press(8'd49);
    press(8'd50);
    press(8'd51);
    check("not yet full", {31'd0, full}, 32'd0);
    press(8'd65);
    check("full",        {31'd0, full},     32'd1);
    check("no ovf yet",  {31'd0, overflow}, 32'd0);
    press(8'd66);
    check("ovf set",     {31'd0, overflow}, 32'd1);
    check("ovf head",    {24'd0, rd_data},  32'd49);
    pop_expect("drain 1", 8'd49);
    check("not full after pop", {31'd0, full}, 32'd0);
    pop_expect("drain 2", 8'd50);
    pop_expect("drain 3", 8'd51);
    pop_expect("drain 4", 8'd65);
    check("drained",     {31'd0, valid},    32'd0);
    check("ovf sticky",  {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    check("ovf cleared", {31'd0, overflow}, 32'd0);

    // 6a. Push coinciding with pop while full
    press(8'd97);
    press(8'd98);
    press(8'd99);
    press(8'd100);
    key_code = 8'd101;
    cyc(4);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    key_code = 8'd0;
    check("full push+pop full", {31'd0, full},     32'd1);
    check("full push+pop ovf",  {31'd0, overflow}, 32'd0);
    cyc(6);
    pop_expect("sim head 1", 8'd98);
    pop_expect("sim head 2", 8'd99);
    pop_expect("sim head 3", 8'd100);
    pop_expect("sim tail",   8'd101);
    check("sim drained", {31'd0, valid}, 32'd0);

    // 6b. Push coinciding with pop at count 1
    press(8'd102);
    key_code = 8'd103;
    cyc(4);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    key_code = 8'd0;
    check("cnt1 valid",   {31'd0, valid},   32'd1);
    check("cnt1 rd_data", {24'd0, rd_data}, 32'd103);
    cyc(6);
    pop_expect("cnt1 pop", 8'd103);
    check("cnt1 drained", {31'd0, valid}, 32'd0);

    // Reset mid-operation: discards queue and in-progress debounce
    press(8'd55);
    key_code = 8'd56;
    cyc(2);
    rst_n = 1'b0;
    cyc();
    key_code = 8'd0;
    rst_n = 1'b1;
    check("mid reset valid", {31'd0, valid}, 32'd0);
    cyc(8);
    check("mid reset no late push", {31'd0, valid}, 32'd0);
    press(8'd57);
    pop_expect("post reset head", 8'd57);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
